// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receive path.
package ps2_pkg;

    localparam int unsigned TMO_W     = 16;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 pin, removes short glitches and flags
// falling edges of the filtered level.
module ps2_line_filter #(
    parameter int unsigned FILT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = 4;

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Level flips only after FILT consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            fall    <= 1'b0;
        end else begin
            sync1   <= line;
            sync2   <= sync1;
            level_d <= level;
            fall    <= level_d & ~level;
            if (sync2 != level) begin
                if (cnt == CNT_W'(FILT - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frame capture with parity/stop/timeout checks
// and E0/F0 prefix folding into single key-event strobes.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILT    = 4,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scancode,
    output logic       flagkey,
    output logic       released,
    output logic       extended,
    output logic       err
);

    logic fall;
    logic data;
    logic clk_level_unused;
    logic data_fall_unused;

    ps2_line_filter #(.FILT(FILT)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .line  (ps2clk),
        .level (clk_level_unused),
        .fall  (fall)
    );

    ps2_line_filter #(.FILT(FILT)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .line  (ps2data),
        .level (data),
        .fall  (data_fall_unused)
    );

    frame_state_e         state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_q, par_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 byte_vld_c;
    logic                 frame_err_c;
    logic                 fsm_err_c;

    logic                 byte_vld_q;
    logic                 frame_err_q;
    logic                 ext_pend;
    logic                 brk_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    // Frame capture, bit counting and inactivity timeout.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = '0;
        byte_vld_c  = 1'b0;
        frame_err_c = 1'b0;
        fsm_err_c   = 1'b0;

        if (state_q != IDLE && !fall) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!data) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        fsm_err_c = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(7)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = data;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data && odd_parity_ok(shift_q, par_q)) begin
                        byte_vld_c = 1'b1;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            tmo_d     = '0;
            fsm_err_c = 1'b1;
        end
    end

    // Prefix folding and event/error strobes; frame errors are delayed one
    // cycle so they line up with the good-byte event latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            scancode    <= '0;
            flagkey     <= 1'b0;
            released    <= 1'b0;
            extended    <= 1'b0;
            err         <= 1'b0;
        end else begin
            byte_vld_q  <= byte_vld_c;
            frame_err_q <= frame_err_c;
            flagkey     <= 1'b0;
            err         <= fsm_err_c | frame_err_q;
            if (fsm_err_c || frame_err_q) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_vld_q) begin
                if (shift_q == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shift_q == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    scancode <= shift_q;
                    extended <= ext_pend;
                    released <= brk_pend;
                    flagkey  <= 1'b1;
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: bit-level PS/2 frames against a
// key-event reference model.
module tb_ps2_scan_rx;

    localparam int FILT    = 4;
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] scancode;
    logic       flagkey;
    logic       released;
    logic       extended;
    logic       err;

    ps2_scan_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2clk   (ps2clk),
        .ps2data  (ps2data),
        .scancode (scancode),
        .flagkey  (flagkey),
        .released (released),
        .extended (extended),
        .err      (err)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    // Strobe monitor.
    int n_flag = 0, n_err = 0, flag_cyc = -1, err_cyc = -1;
    int n_overlap = 0, n_wide = 0;
    logic prev_flag = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (flagkey) begin n_flag++; flag_cyc = cyc; end
        if (err)     begin n_err++;  err_cyc  = cyc; end
        if (flagkey && err) n_overlap++;
        if ((flagkey && prev_flag) || (err && prev_err)) n_wide++;
        prev_flag = flagkey;
        prev_err  = err;
    end

    // Reference model state: held outputs and pending prefixes.
    logic [7:0] m_code = 8'h00;
    logic       m_rel = 1'b0, m_ext = 1'b0;
    logic       m_brk_pend = 1'b0, m_ext_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_start, input bit bad_par,
                              input bit bad_stop, input int nbits, output int last_c);
        logic [10:0] fr;
        fr[0]   = bad_start;
        fr[8:1] = b;
        fr[9]   = (($countones(b) % 2) == 0) ^ bad_par;
        fr[10]  = ~bad_stop;
        last_c  = cyc;
        for (int i = 0; i < nbits; i++) begin
            ps2data = fr[i];
            wait_cyc(10);
            ps2clk = 1'b0;
            last_c = cyc;
            wait_cyc(20);
            ps2clk = 1'b1;
            wait_cyc(10);
        end
        ps2data = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_code"}, 32'(scancode), 32'(m_code));
        check({tag, "_rel"},  32'(released), 32'(m_rel));
        check({tag, "_ext"},  32'(extended), 32'(m_ext));
    endtask

    // Send one frame, predict its outcome from the protocol rules, compare.
    task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_start,
                             input bit bad_par, input bit bad_stop, input int nbits);
        int f0, e0, last_c, exp_c, kind;
        f0 = n_flag;
        e0 = n_err;
        send_frame(b, bad_start, bad_par, bad_stop, nbits, last_c);
        kind  = 0;
        exp_c = last_c;
        if (bad_start) begin
            kind = 2; exp_c = last_c + FILT + 4;
        end else if (nbits < 11) begin
            kind = 2; exp_c = last_c + FILT + 4 + TIMEOUT;
        end else if (bad_par || bad_stop) begin
            kind = 2; exp_c = last_c + FILT + 5;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else begin
            kind   = 1;
            exp_c  = last_c + FILT + 5;
            m_code = b;
            m_rel  = m_brk_pend;
            m_ext  = m_ext_pend;
            m_brk_pend = 1'b0;
            m_ext_pend = 1'b0;
        end
        if (kind == 2) begin
            m_brk_pend = 1'b0;
            m_ext_pend = 1'b0;
        end
        while (cyc < exp_c + 10) wait_cyc(1);
        check({tag, "_nflag"}, 32'(n_flag - f0), 32'(kind == 1));
        check({tag, "_nerr"},  32'(n_err - e0),  32'(kind == 2));
        if (kind == 1) check({tag, "_flag_cyc"}, 32'(flag_cyc), 32'(exp_c));
        if (kind == 2) check({tag, "_err_cyc"},  32'(err_cyc),  32'(exp_c));
        check_outputs(tag);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, e0, lc;
        wait_cyc(3);
        check_outputs("reset");
        check("reset_flag", 32'(flagkey), 32'd0);
        check("reset_err",  32'(err),     32'd0);
        reset = 1'b1;
        wait_cyc(5);

        // Glitch shorter than the filter must be invisible.
        f0 = n_flag; e0 = n_err;
        ps2clk = 1'b0;
        wait_cyc(FILT - 1);
        ps2clk = 1'b1;
        wait_cyc(30);
        check("glitch_flag", 32'(n_flag - f0), 32'd0);
        check("glitch_err",  32'(n_err - e0),  32'd0);

        run_frame("make_1c", 8'h1C, 0, 0, 0, 11);
        run_frame("brk_f0",  8'hF0, 0, 0, 0, 11);
        run_frame("brk_1c",  8'h1C, 0, 0, 0, 11);
        run_frame("ext_e0",  8'hE0, 0, 0, 0, 11);
        run_frame("ext_75",  8'h75, 0, 0, 0, 11);
        run_frame("eb_e0",   8'hE0, 0, 0, 0, 11);
        run_frame("eb_f0",   8'hF0, 0, 0, 0, 11);
        run_frame("eb_75",   8'h75, 0, 0, 0, 11);
        run_frame("plain",   8'h1C, 0, 0, 0, 11);
        run_frame("pe_f0",   8'hF0, 0, 0, 0, 11);
        run_frame("pe_bad",  8'h1C, 0, 1, 0, 11);
        run_frame("pe_next", 8'h1C, 0, 0, 0, 11);
        run_frame("tmo",     8'h29, 0, 0, 0, 5);
        run_frame("tmo_29",  8'h29, 0, 0, 0, 11);

        // Reset mid-frame: outputs clear, partial frame dropped silently.
        f0 = n_flag; e0 = n_err;
        send_frame(8'h5A, 0, 0, 0, 5, lc);
        reset = 1'b0;
        wait_cyc(1);
        m_code = 8'h00; m_rel = 1'b0; m_ext = 1'b0;
        m_brk_pend = 1'b0; m_ext_pend = 1'b0;
        check_outputs("rst_mid");
        check("rst_mid_err", 32'(err), 32'd0);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(TIMEOUT + 50);
        check("rst_flag", 32'(n_flag - f0), 32'd0);
        check("rst_err",  32'(n_err - e0),  32'd0);
        run_frame("rst_29", 8'h29, 0, 0, 0, 11);

        run_frame("start_err", 8'h00, 1, 0, 0, 1);
        run_frame("stop_f0",   8'hF0, 0, 0, 0, 11);
        run_frame("stop_err",  8'h33, 0, 0, 1, 11);
        run_frame("stop_next", 8'h33, 0, 0, 0, 11);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(9);
            b   = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom);
            run_frame("rnd", b, 0, ($urandom_range(7) == 0), ($urandom_range(9) == 0), 11);
        end

        check("strobe_overlap", 32'(n_overlap), 32'd0);
        check("strobe_width",   32'(n_wide),    32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
